mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencing controller that shares the single external memory port between the instruction-fetch stage and the MEM-stage load/store path of the 5-stage MIPS pipeline. It arbitrates the two requesters, runs the request/acknowledge handshake with the memory, and returns read data to the requesters. It drives the `stall` signal that freezes the PC, the IF/ID register (IF_ID_write low) and the later pipeline registers while any access is outstanding. A timeout guards against a memory that never acknowledges.

## Interface
- `ADDR_W`, default 30: word-address width.
- `TIMEOUT`, default 255: maximum wait cycles for `mem_ack`. Legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request, level; held until `i_valid`.
- `i_addr` in ADDR_W: fetch word address; stable while `i_req` is high.
- `i_rdata` out 32: fetched instruction; meaningful only while `i_valid` is high.
- `i_valid` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: data request, level; held until `d_valid`.
- `d_wen` in 1: 1 = store, 0 = load; stable while `d_req` is high.
- `d_addr` in ADDR_W: data word address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data; 0 for stores.
- `d_valid` out 1: one-cycle completion pulse for data.
- `mem_req` out 1: memory request, registered.
- `mem_wen` out 1: memory write enable, registered.
- `mem_addr` out ADDR_W: memory address, registered.
- `mem_wdata` out 32: memory write data, registered.
- `mem_rdata` in 32: memory read data; valid in the `mem_ack` cycle.
- `mem_ack` in 1: single-cycle acknowledge.
- `stall` out 1: pipeline freeze request.
- `err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE transitions:
  - `d_req` high: go to BUSY_D.
  - Otherwise, `i_req` high: go to BUSY_I.
  - Data always wins a tie, because MEM is the older instruction.
- Masking: a request is ignored in IDLE during the cycle in which that requester's own `valid` is high. Its next request is taken in the following cycle.
- On entering BUSY_x, register `mem_req`=1, `mem_addr`, `mem_wen` (0 for fetch), and `mem_wdata`. These hold constant until the state leaves BUSY_x.
- In BUSY_x, `mem_ack` high:
  - Capture `mem_rdata` into `i_rdata` or into `d_rdata` (0 for a store).
  - Pulse that requester's `valid` in the next cycle.
  - Drop `mem_req` and return to IDLE.
- Timeout: an 8-bit wait counter clears on entry to BUSY_x and increments each BUSY cycle without ack. When the count reaches TIMEOUT:
  - Complete the access as if acknowledged, with rdata = 0.
  - Set `err`, which stays set until reset.
- `stall` = (`i_req` & ~`i_valid`) | (`d_req` & ~`d_valid`). It is combinational and low during reset.
- Reset (async, any state) forces:
  - state IDLE and wait counter 0;
  - `mem_req`, `mem_wen`, `i_valid`, `d_valid`, `err` to 0;
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` to 0.
  - Any in-flight access is abandoned. A late `mem_ack` after reset, while in IDLE, is ignored.

## Timing
- Request seen in IDLE at cycle t: `mem_req` is high from t+1.
- `mem_ack` at cycle t+k (k≥1): `valid` and rdata are presented at t+k+1, when the FSM is back in IDLE.
- A pending request for the other requester is granted at t+k+1, giving `mem_req` at t+k+2.
- Minimum fetch turnaround is 3 cycles with zero-wait memory: req→mem_req (1), ack (1), valid (1).
- Simultaneous `i_req`/`d_req`: data is served first, then fetch in back-to-back transactions. `stall` stays high throughout.
- `mem_ack` is only sampled in BUSY states. If ack and timeout coincide in the same cycle, ack wins, real data is returned, and `err` is not set.
- At most one access is outstanding; there is no pipelining on the memory side.

## Structure
- Shared package `mips_mem_pkg`:
  - state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2);
  - wait-counter width (8);
  - default ADDR_W.
- One sub-module, `mem_wait_timer`: 8-bit counter with clear, enable and a `expired` output compared against TIMEOUT. The FSM, output registers and `stall` logic stay in the top module.

## Test plan
- Reset mid-BUSY_D: assert `rst_n`=0 with `mem_req`=1 → all outputs 0 immediately; a subsequent `mem_ack` produces no `valid`.
- Single fetch, `i_addr`=0x10, ack after 2 cycles with `mem_rdata`=0x8C010004 → `mem_req` high for 3 cycles, `i_valid` pulses one cycle later with `i_rdata`=0x8C010004, and `stall` is high from the request cycle until the `valid` cycle.
- Simultaneous `d_req` (load, 0x20) and `i_req` (0x04), zero-wait ack → `mem_addr`=0x20 served first with `d_valid`, then `mem_addr`=0x04 with `i_valid`; `stall` is continuous.
- Store, `d_wen`=1, `d_wdata`=0xDEADBEEF → `mem_wen`=1 and `mem_wdata`=0xDEADBEEF while `mem_req` is high; `d_rdata`=0 at `d_valid`.
- Timeout, TIMEOUT=4, no ack → `d_valid` with `d_rdata`=0 after the 4-cycle wait, `err`=1 and sticky. A following access completes normally.
- Ack arriving on the exact timeout cycle → real data is returned and `err` stays 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and sizes for the IF/MEM memory-port arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam int unsigned WAIT_W     = 8;
  localparam int unsigned DEF_ADDR_W = 30;
  localparam int unsigned DATA_W     = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side handshake bundle. The master view belongs to the
// arbiter (it owns the memory port and answers both requesters); the slave
// view is everything around it: fetch stage, MEM stage and the memory.
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;

  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic              mem_req;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_valid, d_rdata, d_valid, mem_req, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_valid, d_rdata, d_valid, mem_req, mem_wen, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles of one access and flags when the limit is hit.
module mem_wait_timer
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WAIT_W-1:0] count;

  // Wait counter; holds at the limit so it can never wrap past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + WAIT_W'(1);
    end
  end

  assign expired = (count == WAIT_W'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the MEM stage.
// Data wins ties (older instruction); one access outstanding at a time.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus,
  output logic               stall,
  output logic               err
);

  arb_state_t        state;
  logic              mem_req_q;
  logic              mem_wen_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_valid_q;
  logic              d_valid_q;
  logic              busy;
  logic              timer_clr;
  logic              timer_en;
  logic              expired;

  assign busy      = (state != IDLE);
  assign timer_clr = ~busy;
  assign timer_en  = busy & ~bus.mem_ack;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  // Arbitration FSM with registered memory command and requester responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      err         <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          // A requester whose valid is high this cycle is still holding the
          // request it just got answered, so it is masked for one cycle.
          if (bus.d_req && !d_valid_q) begin
            state       <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_wen_q   <= bus.d_wen;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
          end else if (bus.i_req && !i_valid_q) begin
            state       <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
          end
        end
        BUSY_I: begin
          if (bus.mem_ack || expired) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            mem_wen_q <= 1'b0;
            i_valid_q <= 1'b1;
            i_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
            if (!bus.mem_ack) err <= 1'b1;
          end
        end
        BUSY_D: begin
          if (bus.mem_ack || expired) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            mem_wen_q <= 1'b0;
            d_valid_q <= 1'b1;
            d_rdata_q <= (bus.mem_ack && !mem_wen_q) ? bus.mem_rdata : '0;
            if (!bus.mem_ack) err <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
          mem_wen_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.d_valid   = d_valid_q;

  // Freeze the pipeline while either requester is still waiting.
  assign stall = rst_n & ((bus.i_req & ~i_valid_q) | (bus.d_req & ~d_valid_q));

endmodule
